// File: rtl/sndgen_voices_if.sv
// Bundle of the sound generator's frame strobe, voice configuration port and
// mixed/per-voice outputs.
//   sample_ena : one-cycle frame strobe
//   cfg_we     : write strobe for voice cfg_voice (note, mode, vol, hold)
//   sample     : registered mix of all voice levels (4 + log2(NumVoices) bits)
//   voice_o    : registered per-voice levels, voice i at [4i +: 4]
//   busy       : frame processing in progress
// master drives the strobe and configuration, slave is the generator.
interface sndgen_voices_if #(
  parameter int unsigned NumVoices = 4
);
  localparam int unsigned ViW  = $clog2(NumVoices);
  localparam int unsigned SumW = 4 + ViW;

  logic                   sample_ena;
  logic                   cfg_we;
  logic [ViW-1:0]         cfg_voice;
  logic [3:0]             cfg_note;
  logic [1:0]             cfg_mode;
  logic [3:0]             cfg_vol;
  logic                   cfg_hold;
  logic [SumW-1:0]        sample;
  logic [4*NumVoices-1:0] voice_o;
  logic                   busy;

  modport master (
    output sample_ena, cfg_we, cfg_voice, cfg_note, cfg_mode, cfg_vol, cfg_hold,
    input  sample, voice_o, busy
  );

  modport slave (
    input  sample_ena, cfg_we, cfg_voice, cfg_note, cfg_mode, cfg_vol, cfg_hold,
    output sample, voice_o, busy
  );
endinterface

// File: rtl/sndgen_voices.sv
// Multi-voice sound generator. Each voice has a note (phase increment), a waveform
// (off/square/saw/noise) and a 4-bit envelope with optional linear decay. After an
// accepted sample_ena strobe the voices are processed one per clock and summed into
// one unsigned sample.
// Ports:
//   clk_i  : system clock
//   rst_i  : synchronous, active-high reset
//   snd_io : sndgen_voices_if slave (strobe, voice config write port, sample/voice_o/busy)
module sndgen_voices #(
  parameter int unsigned SampleRate = 16384,
  parameter int unsigned NumVoices  = 4,
  parameter int unsigned DecayShift = 11
) (
  input  logic           clk_i,
  input  logic           rst_i,
  sndgen_voices_if.slave snd_io
);
  localparam int unsigned PhW  = $clog2(SampleRate);
  localparam int unsigned ViW  = $clog2(NumVoices);
  localparam int unsigned SumW = 4 + ViW;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  // Phase increment per frame; frame rate equals SampleRate so this is the note in Hz.
  function automatic logic [8:0] note_inc(input logic [3:0] note);
    logic [8:0] inc;
    case (note)
      4'd1:    inc = 9'd262;
      4'd2:    inc = 9'd277;
      4'd3:    inc = 9'd294;
      4'd4:    inc = 9'd311;
      4'd5:    inc = 9'd330;
      4'd6:    inc = 9'd349;
      4'd7:    inc = 9'd370;
      4'd8:    inc = 9'd392;
      4'd9:    inc = 9'd415;
      4'd10:   inc = 9'd440;
      4'd11:   inc = 9'd466;
      4'd12:   inc = 9'd494;
      default: inc = 9'd0;
    endcase
    return inc;
  endfunction

  state_e                 state_q, state_d;
  logic [ViW-1:0]         vidx_q, vidx_d;
  logic [SumW-1:0]        acc_q, acc_d;
  logic [SumW-1:0]        sample_q, sample_d;
  logic [4*NumVoices-1:0] voice_q, voice_d;
  logic [DecayShift-1:0]  frame_q, frame_d;
  logic                   tick_q, tick_d;
  logic [15:0]            lfsr_q, lfsr_d;

  logic [PhW-1:0] phase_q [NumVoices];
  logic [PhW-1:0] phase_d [NumVoices];
  logic [3:0]     env_q   [NumVoices];
  logic [3:0]     env_d   [NumVoices];
  logic [3:0]     note_q  [NumVoices];
  logic [3:0]     note_d  [NumVoices];
  logic [1:0]     mode_q  [NumVoices];
  logic [1:0]     mode_d  [NumVoices];
  logic           hold_q  [NumVoices];
  logic           hold_d  [NumVoices];

  // Level of the voice selected by vidx_q, from pre-edge register values.
  logic [8:0]      cur_inc;
  logic [PhW-1:0]  cur_phase;
  logic [1:0]      cur_mode;
  logic [3:0]      cur_env;
  logic [3:0]      cur_wave;
  logic [7:0]      cur_prod;
  logic [3:0]      cur_level;
  logic [SumW-1:0] acc_sum;

  always_comb begin
    cur_inc   = note_inc(note_q[vidx_q]);
    cur_phase = phase_q[vidx_q];
    cur_mode  = mode_q[vidx_q];
    cur_env   = env_q[vidx_q];
    unique case (cur_mode)
      2'd1:    cur_wave = cur_phase[PhW-1] ? 4'hf : 4'h0;
      2'd2:    cur_wave = cur_phase[PhW-1 -: 4];
      2'd3:    cur_wave = lfsr_q[3:0];
      default: cur_wave = 4'h0;
    endcase
    cur_prod  = {4'd0, cur_wave} * {4'd0, cur_env};
    cur_level = (cur_mode == 2'd0 || cur_inc == 9'd0) ? 4'h0 : cur_prod[7:4];
    acc_sum   = acc_q + SumW'(cur_level);
  end

  always_comb begin
    state_d  = state_q;
    vidx_d   = vidx_q;
    acc_d    = acc_q;
    sample_d = sample_q;
    voice_d  = voice_q;
    frame_d  = frame_q;
    tick_d   = tick_q;
    phase_d  = phase_q;
    env_d    = env_q;
    note_d   = note_q;
    mode_d   = mode_q;
    hold_d   = hold_q;
    lfsr_d   = lfsr_q[15] ? ({lfsr_q[14:0], 1'b1} ^ 16'h0805) : {lfsr_q[14:0], 1'b0};

    unique case (state_q)
      StIdle: begin
        if (snd_io.sample_ena) begin
          state_d = StRun;
          vidx_d  = '0;
        end
      end
      StRun: begin
        voice_d[{vidx_q, 2'b00} +: 4] = cur_level;
        phase_d[vidx_q] = (cur_mode == 2'd0) ? '0 : cur_phase + PhW'(cur_inc);
        if (tick_q && !hold_q[vidx_q] && cur_env != 4'd0) begin
          env_d[vidx_q] = cur_env - 4'd1;
        end
        if (vidx_q == ViW'(NumVoices - 1)) begin
          sample_d = acc_sum;
          acc_d    = '0;
          state_d  = StIdle;
          frame_d  = frame_q + 1'b1;
          // Counter is about to wrap to 0: the next frame decays.
          tick_d   = &frame_q;
        end else begin
          acc_d  = acc_sum;
          vidx_d = vidx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Config write overrides any same-edge processing update of that voice.
    if (snd_io.cfg_we) begin
      note_d[snd_io.cfg_voice]  = snd_io.cfg_note;
      mode_d[snd_io.cfg_voice]  = snd_io.cfg_mode;
      hold_d[snd_io.cfg_voice]  = snd_io.cfg_hold;
      env_d[snd_io.cfg_voice]   = snd_io.cfg_vol;
      phase_d[snd_io.cfg_voice] = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      vidx_q   <= '0;
      acc_q    <= '0;
      sample_q <= '0;
      voice_q  <= '0;
      frame_q  <= '0;
      tick_q   <= 1'b0;
      lfsr_q   <= 16'hdead;
      for (int i = 0; i < NumVoices; i++) begin
        phase_q[i] <= '0;
        env_q[i]   <= '0;
        note_q[i]  <= '0;
        mode_q[i]  <= '0;
        hold_q[i]  <= 1'b0;
      end
    end else begin
      state_q  <= state_d;
      vidx_q   <= vidx_d;
      acc_q    <= acc_d;
      sample_q <= sample_d;
      voice_q  <= voice_d;
      frame_q  <= frame_d;
      tick_q   <= tick_d;
      lfsr_q   <= lfsr_d;
      phase_q  <= phase_d;
      env_q    <= env_d;
      note_q   <= note_d;
      mode_q   <= mode_d;
      hold_q   <= hold_d;
    end
  end

  assign snd_io.sample  = sample_q;
  assign snd_io.voice_o = voice_q;
  assign snd_io.busy    = (state_q == StRun);
endmodule

// File: tb/tb_sndgen_voices.sv
// Directed bench for sndgen_voices: a frame-level model predicts each frame's sample
// and voice levels at strobe time into a scoreboard queue, which is popped and
// compared when the frame completes. Fixed spot values are also checked.
module tb_sndgen_voices;
  localparam int unsigned NV = 4;
  localparam int unsigned DS = 2;
  localparam int unsigned SR = 16384;

  typedef struct {
    logic [5:0]  sample;
    logic [15:0] voice;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sndgen_voices_if #(.NumVoices(NV)) snd ();

  sndgen_voices #(
    .SampleRate(SR),
    .NumVoices (NV),
    .DecayShift(DS)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .snd_io(snd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return l[15] ? ({l[14:0], 1'b1} ^ 16'h0805) : {l[14:0], 1'b0};
  endfunction

  // Reference noise source, advanced every clock like the spec's LFSR.
  logic [15:0] tb_lfsr = 16'hdead;
  always @(posedge clk) tb_lfsr <= rst ? 16'hdead : lstep(tb_lfsr);

  function automatic int rom(input int n);
    case (n)
      1: return 262;   2: return 277;   3: return 294;   4: return 311;
      5: return 330;   6: return 349;   7: return 370;   8: return 392;
      9: return 415;  10: return 440;  11: return 466;  12: return 494;
      default: return 0;
    endcase
  endfunction

  int   m_phase[NV], m_env[NV], m_mode[NV], m_note[NV], m_hold[NV];
  int   m_cnt;
  bit   m_tick;
  exp_t sb[$];

  function automatic void m_reset();
    for (int i = 0; i < NV; i++) begin
      m_phase[i] = 0; m_env[i] = 0; m_mode[i] = 0; m_note[i] = 0; m_hold[i] = 0;
    end
    m_cnt  = 0;
    m_tick = 1'b0;
    sb.delete();
  endfunction

  function automatic void m_write(input int v, input int n, input int m, input int vol,
                                  input int h);
    m_note[v] = n; m_mode[v] = m; m_env[v] = vol; m_hold[v] = h; m_phase[v] = 0;
  endfunction

  // All tasks start and end right after a falling edge.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic cfg(input int v, input int n, input int m, input int vol, input int h);
    snd.cfg_we    = 1'b1;
    snd.cfg_voice = 2'(v);
    snd.cfg_note  = 4'(n);
    snd.cfg_mode  = 2'(m);
    snd.cfg_vol   = 4'(vol);
    snd.cfg_hold  = 1'(h);
    @(negedge clk);
    snd.cfg_we = 1'b0;
    m_write(v, n, m, vol, h);
  endtask

  // One 8-clock frame. strobe2 adds a strobe while busy; cwe writes voice cv on its
  // processing edge.
  task automatic run_frame(input bit strobe2, input bit cwe, input int cv, input int cn,
                           input int cm, input int cvol, input int ch);
    logic [15:0] l;
    exp_t        e;
    exp_t        got;
    int          acc, inc, wave, lvl;
    l = tb_lfsr;
    acc = 0;
    e.voice = '0;
    for (int i = 0; i < NV; i++) begin
      l   = lstep(l);
      inc = rom(m_note[i]);
      case (m_mode[i])
        1: wave = (m_phase[i] >= SR / 2) ? 15 : 0;
        2: wave = (m_phase[i] * 16) / SR;
        3: wave = int'(l[3:0]);
        default: wave = 0;
      endcase
      lvl = (m_mode[i] == 0 || inc == 0) ? 0 : (wave * m_env[i]) / 16;
      e.voice[4*i +: 4] = 4'(lvl);
      acc += lvl;
      m_phase[i] = (m_mode[i] == 0) ? 0 : (m_phase[i] + inc) % SR;
      if (m_tick && m_hold[i] == 0 && m_env[i] > 0) m_env[i]--;
      if (cwe && i == cv) m_write(cv, cn, cm, cvol, ch);
    end
    e.sample = 6'(acc);
    sb.push_back(e);
    m_cnt  = (m_cnt + 1) % (1 << DS);
    m_tick = (m_cnt == 0);

    snd.sample_ena = 1'b1;
    @(negedge clk);
    snd.sample_ena = 1'b0;
    check("busy_set", snd.busy, 1);
    for (int k = 1; k <= NV; k++) begin
      if (cwe && k == cv + 1) begin
        snd.cfg_we    = 1'b1;
        snd.cfg_voice = 2'(cv);
        snd.cfg_note  = 4'(cn);
        snd.cfg_mode  = 2'(cm);
        snd.cfg_vol   = 4'(cvol);
        snd.cfg_hold  = 1'(ch);
      end
      if (strobe2 && k == 2) snd.sample_ena = 1'b1;
      @(negedge clk);
      snd.cfg_we     = 1'b0;
      snd.sample_ena = 1'b0;
    end
    check("busy_clr", snd.busy, 0);
    got = sb.pop_front();
    check("sb_sample", snd.sample, got.sample);
    check("sb_voice", snd.voice_o, got.voice);
    @(negedge clk);
    check("busy_idle", snd.busy, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    snd.sample_ena = 1'b0;
    snd.cfg_we     = 1'b0;
    snd.cfg_voice  = '0;
    snd.cfg_note   = '0;
    snd.cfg_mode   = '0;
    snd.cfg_vol    = '0;
    snd.cfg_hold   = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", snd.busy, 0);
    check("rst_sample", snd.sample, 0);
    check("rst_voice", snd.voice_o, 0);

    // Square note 10 on voice 0: high once phase reaches 8192, low again after wrap.
    cfg(0, 10, 1, 15, 1);
    for (int f = 0; f < 40; f++) begin
      run_frame(0, 0, 0, 0, 0, 0, 0);
      if (f == 18) check("t2_f18", snd.sample, 0);
      if (f == 19) check("t2_f19", snd.sample, 14);
      if (f == 38) check("t2_wrap", snd.sample, 0);
    end

    // Saw note 1 on voice 1.
    do_reset();
    cfg(1, 1, 2, 15, 1);
    for (int f = 0; f <= 40; f++) begin
      run_frame(0, 0, 0, 0, 0, 0, 0);
      if (f == 40) check("t3_f40", snd.voice_o[7:4], 9);
    end

    // Four identical square voices.
    do_reset();
    for (int v = 0; v < NV; v++) cfg(v, 10, 1, 15, 1);
    for (int f = 0; f < 20; f++) begin
      run_frame(0, 0, 0, 0, 0, 0, 0);
      if (f == 18) check("t5_f18", snd.sample, 0);
      if (f == 19) check("t5_f19", snd.sample, 56);
    end

    // Reset in the middle of a frame.
    snd.sample_ena = 1'b1;
    @(negedge clk);
    snd.sample_ena = 1'b0;
    @(negedge clk);
    check("t1_busy_mid", snd.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    check("t1_busy", snd.busy, 0);
    check("t1_sample", snd.sample, 0);
    check("t1_voice", snd.voice_o, 0);
    // Noise voice: levels follow the LFSR restarted from 16'hdead.
    cfg(0, 10, 3, 15, 1);
    for (int f = 0; f < 4; f++) run_frame(0, 0, 0, 0, 0, 0, 0);

    // Decay every 4 frames (DecayShift 2), then a hold rewrite.
    do_reset();
    cfg(0, 12, 1, 15, 0);
    for (int f = 0; f < 72; f++) begin
      run_frame(0, 0, 0, 0, 0, 0, 0);
      if (f == 52) check("t4_env3", snd.sample, 2);
      if (f == 64) check("t4_env0", snd.sample, 0);
    end
    cfg(0, 12, 1, 15, 1);
    for (int f = 0; f < 24; f++) begin
      run_frame(0, 0, 0, 0, 0, 0, 0);
      if (f == 20) check("t4_hold", snd.sample, 14);
    end

    // Ignored strobe while busy plus a write colliding with voice 2's processing edge.
    do_reset();
    cfg(2, 12, 2, 15, 1);
    for (int f = 0; f < 10; f++) run_frame(0, 0, 0, 0, 0, 0, 0);
    run_frame(1, 1, 2, 5, 2, 7, 1);
    check("t6_old_level", snd.voice_o[11:8], 3);
    for (int f = 0; f <= 16; f++) begin
      run_frame(0, 0, 0, 0, 0, 0, 0);
      if (f == 0)  check("t6_phase0", snd.voice_o[11:8], 0);
      if (f == 16) check("t6_new_env", snd.voice_o[11:8], 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
